// File: rtl/if_fetch_pair_pkg.sv
// Shared constants, FSM state type and address helper for the IF fetch-pair stage.
package if_fetch_pair_pkg;

  localparam int unsigned LINE_IF_TO_ID_BUS_W = 64;
  localparam int unsigned IF_TO_ID_BUS_W      = 2 * LINE_IF_TO_ID_BUS_W;
  localparam logic        RST_ENABLE          = 1'b1;
  localparam logic [31:0] RESET_PC_DEF        = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // 8-byte aligned base of the instruction pair containing pc
  function automatic logic [31:0] pair_base(input logic [31:0] pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/if_fetch_pair_align.sv
// Splits a fetched 64-bit pair into the {pc,inst} lines handed to IF_ID.
module if_pair_align
  import if_fetch_pair_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_IF_TO_ID_BUS_W
) (
  input  logic [63:0]       rdata,
  input  logic [31:0]       pc,
  output logic [LINE_W-1:0] line1,
  output logic [LINE_W-1:0] line2,
  output logic              line2_valid
);

  // An odd-word pc starts in the upper half, leaving no second line
  always_comb begin
    line1       = {pc, (pc[2] ? rdata[63:32] : rdata[31:0])};
    line2_valid = ~pc[2];
    line2       = '0;
    if (!pc[2]) begin
      line2 = {pc + 32'd4, rdata[63:32]};
    end
  end

endmodule

// File: rtl/if_fetch_pair.sv
// IF stage: one outstanding 64-bit pair fetch, buffered and presented as two
// {pc,inst} lines to IF_ID, with branch/exception redirect handling.
module if_fetch_pair
  import if_fetch_pair_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned LINE_W   = LINE_IF_TO_ID_BUS_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                allowin_i,
  output logic                line1_to_id_valid_o,
  output logic                line2_to_id_valid_o,
  output logic [2*LINE_W-1:0] to_ifid_obus,
  input  logic                branch_flush_i,
  input  logic [31:0]         branch_target_i,
  input  logic                excep_flush_i,
  input  logic [31:0]         excep_entry_i,
  output logic                inst_sram_req_o,
  output logic [31:0]         inst_sram_addr_o,
  input  logic                inst_sram_addr_ok_i,
  input  logic                inst_sram_data_ok_i,
  input  logic [63:0]         inst_sram_rdata_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         discard_q, discard_d;
  logic [63:0]  buf_q, buf_d;

  logic         flush;
  logic [31:0]  flush_pc;
  logic [31:0]  seq_pc;
  logic         live;
  logic         in_hold;
  logic [LINE_W-1:0] line1, line2;
  logic         line2_ok;

  // Next state, pc, request address, discard flag and response buffer
  always_comb begin
    flush     = excep_flush_i | branch_flush_i;
    flush_pc  = excep_flush_i ? excep_entry_i : branch_target_i;
    seq_pc    = pair_base(pc_q) + 32'd8;
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    case (state_q)
      ST_REQ: begin
        // A request already on the bus must stay stable; its answer is dropped
        // and the redirect address is loaded once that answer arrives.
        if (flush) begin
          pc_d      = flush_pc;
          discard_d = 1'b1;
          if (inst_sram_addr_ok_i) begin
            addr_d = pair_base(flush_pc);
          end
        end
        if (inst_sram_addr_ok_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          pc_d   = flush_pc;
          addr_d = pair_base(flush_pc);
          if (inst_sram_data_ok_i) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (inst_sram_data_ok_i) begin
          if (discard_q) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
            addr_d    = pair_base(pc_q);
          end else begin
            buf_d   = inst_sram_rdata_i;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          addr_d  = pair_base(flush_pc);
          buf_d   = '0;
          state_d = ST_REQ;
        end else if (allowin_i) begin
          pc_d    = seq_pc;
          addr_d  = seq_pc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Fetch state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      addr_q    <= pair_base(RESET_PC);
      discard_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
    end
  end

  if_pair_align #(
    .LINE_W(LINE_W)
  ) u_align (
    .rdata       (buf_q),
    .pc          (pc_q),
    .line1       (line1),
    .line2       (line2),
    .line2_valid (line2_ok)
  );

  // Bus request and IF_ID handoff; a flushing cycle never presents data
  always_comb begin
    live                = (rst_n != RST_ENABLE);
    in_hold             = live && (state_q == ST_HOLD);
    inst_sram_req_o     = live && (state_q == ST_REQ);
    inst_sram_addr_o    = addr_q;
    line1_to_id_valid_o = in_hold && !flush;
    line2_to_id_valid_o = in_hold && !flush && line2_ok;
    to_ifid_obus        = in_hold ? {line2, line1} : '0;
  end

endmodule
